// File: rtl/cfu_seq.sv
// Sequential control-flow unit: owns EIP, resolves Jcc/LOOPcc/CALL/JMP/RET targets one instruction
// per handshake, and shadows CALL/RET pairs on a circular return-address stack with sticky faults.
module cfu_seq #(
   parameter int               ADDR_W        = 32,
   parameter int               LEN_W         = 4,
   parameter int               RAS_DEPTH     = 8,
   parameter logic [ADDR_W-1:0] RESET_EIP    = '0,
   parameter bit               HALT_ON_FAULT = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        opc,
   input  logic [31:0]       eflags,
   input  logic              ecx_is_zero,
   input  logic [LEN_W-1:0]  instr_len,
   input  logic [ADDR_W-1:0] address,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] eip,
   output logic              ras_mismatch,
   output logic              ras_underflow,
   output logic              ras_overflow,
   output logic              fault
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   // Command codes
   localparam logic [6:0] CMD_JO     = 7'h10;
   localparam logic [6:0] CMD_JNO    = 7'h11;
   localparam logic [6:0] CMD_JB     = 7'h12;
   localparam logic [6:0] CMD_JAE    = 7'h13;
   localparam logic [6:0] CMD_JE     = 7'h14;
   localparam logic [6:0] CMD_JNE    = 7'h15;
   localparam logic [6:0] CMD_JBE    = 7'h16;
   localparam logic [6:0] CMD_JA     = 7'h17;
   localparam logic [6:0] CMD_JS     = 7'h18;
   localparam logic [6:0] CMD_JNS    = 7'h19;
   localparam logic [6:0] CMD_JP     = 7'h1a;
   localparam logic [6:0] CMD_JNP    = 7'h1b;
   localparam logic [6:0] CMD_JL     = 7'h1c;
   localparam logic [6:0] CMD_JNL    = 7'h1d;
   localparam logic [6:0] CMD_JLE    = 7'h1e;
   localparam logic [6:0] CMD_JG     = 7'h1f;
   localparam logic [6:0] CMD_JCXZ   = 7'h20;
   localparam logic [6:0] CMD_LOOP   = 7'h21;
   localparam logic [6:0] CMD_LOOPE  = 7'h22;
   localparam logic [6:0] CMD_LOOPNE = 7'h23;
   localparam logic [6:0] CMD_CALLR  = 7'h24;
   localparam logic [6:0] CMD_CALLI  = 7'h25;
   localparam logic [6:0] CMD_JMPR   = 7'h26;
   localparam logic [6:0] CMD_JMPI   = 7'h27;
   localparam logic [6:0] CMD_RET    = 7'h28;

   // EFLAGS bit positions (x86 layout)
   localparam int EFLAGS_CF = 0;
   localparam int EFLAGS_PF = 2;
   localparam int EFLAGS_ZF = 6;
   localparam int EFLAGS_SF = 7;
   localparam int EFLAGS_OF = 11;

   generate
      if (ADDR_W < LEN_W) begin : g_bad_addr_w
         $error("cfu_seq: ADDR_W must be >= LEN_W");
      end
      if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("cfu_seq: RAS_DEPTH must be a power of 2 and >= 2");
      end
   endgenerate

   typedef enum logic {
      ST_RUN,
      ST_FAULT
   } state_t;

   state_t state, state_nxt;

   logic              cf, pf, zf, sf, of;
   logic              cc;
   logic              is_call, is_ret, is_jmp, is_abs, xfer;
   logic              accept;
   logic [ADDR_W-1:0] seq_eip, next_eip;

   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]  ras_ptr;      // next free slot; oldest entry when full
   logic [PTR_W-1:0]  ras_top_idx;
   logic [PTR_W:0]    ras_cnt;
   logic              ras_empty, ras_full;
   logic              ret_mismatch, ret_underflow;

   logic              unused_eflags;

   assign cf = eflags[EFLAGS_CF];
   assign pf = eflags[EFLAGS_PF];
   assign zf = eflags[EFLAGS_ZF];
   assign sf = eflags[EFLAGS_SF];
   assign of = eflags[EFLAGS_OF];
   assign unused_eflags = ^{eflags[31:12], eflags[10:8], eflags[5:3], eflags[1]};

   // NOTE: every output of a combinational block gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      cc = 1'b0;
      case (opc)
         CMD_JO:     cc = of;
         CMD_JNO:    cc = !of;
         CMD_JB:     cc = cf;
         CMD_JAE:    cc = !cf;
         CMD_JE:     cc = zf;
         CMD_JNE:    cc = !zf;
         CMD_JBE:    cc = cf | zf;
         CMD_JA:     cc = !cf & !zf;
         CMD_JS:     cc = sf;
         CMD_JNS:    cc = !sf;
         CMD_JP:     cc = pf;
         CMD_JNP:    cc = !pf;
         CMD_JL:     cc = sf != of;
         CMD_JNL:    cc = sf == of;
         CMD_JLE:    cc = zf | (sf != of);
         CMD_JG:     cc = !zf & (sf == of);
         CMD_JCXZ:   cc = ecx_is_zero;
         CMD_LOOP:   cc = !ecx_is_zero;
         CMD_LOOPE:  cc = !ecx_is_zero & zf;
         CMD_LOOPNE: cc = !ecx_is_zero & !zf;
         default:    cc = 1'b0;
      endcase
   end

   assign is_call = (opc == CMD_CALLR) | (opc == CMD_CALLI);
   assign is_ret  = (opc == CMD_RET);
   assign is_jmp  = (opc == CMD_JMPR) | (opc == CMD_JMPI);
   assign is_abs  = (opc == CMD_CALLI) | (opc == CMD_JMPI) | is_ret;
   assign xfer    = cc | is_call | is_jmp | is_ret;

   assign seq_eip  = eip + ADDR_W'(instr_len);
   assign next_eip = !xfer ? seq_eip : (is_abs ? address : seq_eip + address);

   assign in_ready = (state == ST_RUN) & (!out_valid | out_ready);
   assign accept   = in_valid & in_ready;

   assign ras_top_idx   = ras_ptr - PTR_W'(1);
   assign ras_empty     = (ras_cnt == '0);
   assign ras_full      = (ras_cnt == (PTR_W + 1)'(RAS_DEPTH));
   assign ret_underflow = accept & is_ret & ras_empty;
   assign ret_mismatch  = accept & is_ret & !ras_empty & (ras_mem[ras_top_idx] != address);

   // NOTE: sequential state is assigned with non-blocking <= so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         eip           <= RESET_EIP;
         out_valid     <= 1'b0;
         ras_ptr       <= '0;
         ras_cnt       <= '0;
         ras_mismatch  <= 1'b0;
         ras_underflow <= 1'b0;
         ras_overflow  <= 1'b0;
      end else begin
         if (accept) begin
            eip <= next_eip;
         end
         if (accept) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (accept && is_call) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_full) begin
               ras_overflow <= 1'b1;
            end else begin
               ras_cnt <= ras_cnt + (PTR_W + 1)'(1);
            end
         end else if (accept && is_ret && !ras_empty) begin
            ras_ptr <= ras_top_idx;
            ras_cnt <= ras_cnt - (PTR_W + 1)'(1);
         end

         if (ret_mismatch) begin
            ras_mismatch <= 1'b1;
         end
         if (ret_underflow) begin
            ras_underflow <= 1'b1;
         end
      end
   end

   // NOTE: the stack storage has no reset; ras_cnt gates every read, so stale entries are
   // never observed and the array can map onto plain RAM/flops without a reset net.
   always_ff @(posedge clk) begin
      if (!rst && accept && is_call) begin
         ras_mem[ras_ptr] <= seq_eip;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fault     = 1'b0;
      case (state)
         ST_RUN: begin
            if (HALT_ON_FAULT && (ret_mismatch || ret_underflow)) begin
               state_nxt = ST_FAULT;
            end
         end
         ST_FAULT: begin
            fault = 1'b1;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_cfu_seq.sv
// Self-checking bench for cfu_seq: directed scenarios plus randomized traffic against a
// list-based reference model, on a halting (dut 0) and a flag-only (dut 1) instance.
module tb_cfu_seq;

   localparam int          D      = 4;
   localparam logic [31:0] RST_IP = 32'h0000_1000;

   localparam logic [6:0] NOP    = 7'h00;
   localparam logic [6:0] JO     = 7'h10;
   localparam logic [6:0] JNO    = 7'h11;
   localparam logic [6:0] JB     = 7'h12;
   localparam logic [6:0] JAE    = 7'h13;
   localparam logic [6:0] JE     = 7'h14;
   localparam logic [6:0] JNE    = 7'h15;
   localparam logic [6:0] JBE    = 7'h16;
   localparam logic [6:0] JA     = 7'h17;
   localparam logic [6:0] JS     = 7'h18;
   localparam logic [6:0] JNS    = 7'h19;
   localparam logic [6:0] JP     = 7'h1a;
   localparam logic [6:0] JNP    = 7'h1b;
   localparam logic [6:0] JL     = 7'h1c;
   localparam logic [6:0] JNL    = 7'h1d;
   localparam logic [6:0] JLE    = 7'h1e;
   localparam logic [6:0] JG     = 7'h1f;
   localparam logic [6:0] JCXZ   = 7'h20;
   localparam logic [6:0] LOOP   = 7'h21;
   localparam logic [6:0] LOOPE  = 7'h22;
   localparam logic [6:0] LOOPNE = 7'h23;
   localparam logic [6:0] CALLR  = 7'h24;
   localparam logic [6:0] CALLI  = 7'h25;
   localparam logic [6:0] JMPR   = 7'h26;
   localparam logic [6:0] JMPI   = 7'h27;
   localparam logic [6:0] RET    = 7'h28;

   localparam logic [6:0] OPC_TAB [0:27] = '{
      NOP, 7'h05, JO, JNO, JB, JAE, JE, JNE, JBE, JA, JS, JNS, JP, JNP, JL, JNL, JLE, JG,
      JCXZ, LOOP, LOOPE, LOOPNE, CALLR, CALLI, JMPR, JMPI, RET, RET};

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [6:0]  opc;
   logic [31:0] eflags;
   logic        ecx_is_zero;
   logic [3:0]  instr_len;
   logic [31:0] address;
   logic        out_ready;

   logic        d_rdy   [2];
   logic        d_ov    [2];
   logic [31:0] d_eip   [2];
   logic        d_mis   [2];
   logic        d_und   [2];
   logic        d_ovf   [2];
   logic        d_fault [2];
   logic [37:0] obs     [2];

   // reference model state, one per instance
   logic [31:0] m_eip   [2];
   logic        m_ov    [2];
   logic        m_mis   [2];
   logic        m_und   [2];
   logic        m_ovf   [2];
   logic        m_fault [2];
   int          m_cnt   [2];
   logic [31:0] m_ras   [2][D];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cfu_seq #(.ADDR_W(32), .LEN_W(4), .RAS_DEPTH(D), .RESET_EIP(RST_IP), .HALT_ON_FAULT(1'b1)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_rdy[0]), .opc(opc), .eflags(eflags),
      .ecx_is_zero(ecx_is_zero), .instr_len(instr_len), .address(address), .out_valid(d_ov[0]),
      .out_ready(out_ready), .eip(d_eip[0]), .ras_mismatch(d_mis[0]), .ras_underflow(d_und[0]),
      .ras_overflow(d_ovf[0]), .fault(d_fault[0]));

   cfu_seq #(.ADDR_W(32), .LEN_W(4), .RAS_DEPTH(D), .RESET_EIP(RST_IP), .HALT_ON_FAULT(1'b0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_rdy[1]), .opc(opc), .eflags(eflags),
      .ecx_is_zero(ecx_is_zero), .instr_len(instr_len), .address(address), .out_valid(d_ov[1]),
      .out_ready(out_ready), .eip(d_eip[1]), .ras_mismatch(d_mis[1]), .ras_underflow(d_und[1]),
      .ras_overflow(d_ovf[1]), .fault(d_fault[1]));

   // observation vector: {eip, out_valid, mismatch, underflow, overflow, fault, in_ready}
   assign obs[0] = {d_eip[0], d_ov[0], d_mis[0], d_und[0], d_ovf[0], d_fault[0], d_rdy[0]};
   assign obs[1] = {d_eip[1], d_ov[1], d_mis[1], d_und[1], d_ovf[1], d_fault[1], d_rdy[1]};

   task automatic model_step(input int k);
      bit          halt = (k == 0);
      bit          cf = eflags[0], pf = eflags[2], zf = eflags[6], sf = eflags[7], of = eflags[11];
      bit          cc, rdy, acc, call, ret, absj, xfer;
      logic [31:0] seq;
      if (rst) begin
         m_eip[k] = RST_IP; m_ov[k] = 1'b0; m_mis[k] = 1'b0; m_und[k] = 1'b0;
         m_ovf[k] = 1'b0; m_fault[k] = 1'b0; m_cnt[k] = 0;
         return;
      end
      rdy = !m_fault[k] && (!m_ov[k] || out_ready);
      acc = in_valid && rdy;
      if (acc) begin
         case (opc)
            JO: cc = of;            JNO: cc = !of;
            JB: cc = cf;            JAE: cc = !cf;
            JE: cc = zf;            JNE: cc = !zf;
            JBE: cc = cf || zf;     JA: cc = !cf && !zf;
            JS: cc = sf;            JNS: cc = !sf;
            JP: cc = pf;            JNP: cc = !pf;
            JL: cc = sf != of;      JNL: cc = sf == of;
            JLE: cc = zf || (sf != of);
            JG: cc = !zf && (sf == of);
            JCXZ: cc = ecx_is_zero; LOOP: cc = !ecx_is_zero;
            LOOPE: cc = !ecx_is_zero && zf;
            LOOPNE: cc = !ecx_is_zero && !zf;
            default: cc = 1'b0;
         endcase
         call = (opc == CALLR) || (opc == CALLI);
         ret  = (opc == RET);
         absj = (opc == CALLI) || (opc == JMPI) || ret;
         xfer = cc || call || ret || (opc == JMPR) || (opc == JMPI);
         seq  = m_eip[k] + {28'd0, instr_len};
         m_eip[k] = !xfer ? seq : (absj ? address : seq + address);
         if (call) begin
            if (m_cnt[k] == D) begin
               for (int i = 0; i < D - 1; i++) m_ras[k][i] = m_ras[k][i+1];
               m_ras[k][D-1] = seq;
               m_ovf[k] = 1'b1;
            end else begin
               m_ras[k][m_cnt[k]] = seq;
               m_cnt[k]++;
            end
         end
         if (ret) begin
            if (m_cnt[k] > 0) begin
               m_cnt[k]--;
               if (m_ras[k][m_cnt[k]] != address) begin
                  m_mis[k] = 1'b1;
                  if (halt) m_fault[k] = 1'b1;
               end
            end else begin
               m_und[k] = 1'b1;
               if (halt) m_fault[k] = 1'b1;
            end
         end
      end
      m_ov[k] = acc ? 1'b1 : (out_ready ? 1'b0 : m_ov[k]);
   endtask

   task automatic step(input bit r, input bit v, input bit ordy, input logic [6:0] o,
                       input logic [31:0] fl, input bit cz, input logic [3:0] len,
                       input logic [31:0] a);
      @(negedge clk);
      rst = r; in_valid = v; out_ready = ordy; opc = o; eflags = fl;
      ecx_is_zero = cz; instr_len = len; address = a;
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1, 1, 1, JMPI, '0, 0, 4'd1, 32'h55);
      step(0, 0, 1, NOP, '0, 0, 4'd0, '0);
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs[k] !== {RST_IP, 1'b0, 4'b0000, 1'b1}) begin
            bad++;
            $display("FAIL reset dut%0d: got %h want %h", k, obs[k], {RST_IP, 1'b0, 4'b0000, 1'b1});
         end
      end
   endtask

   task automatic test_jcc();
      step(1, 0, 1, NOP, '0, 0, 4'd0, '0);
      step(0, 1, 1, JE, 32'h40, 0, 4'd2, 32'h10);
      total++;
      if (obs[0] !== {32'h1012, 1'b1, 4'b0000, 1'b1}) begin
         bad++; $display("FAIL je_taken: got %h want %h", obs[0], {32'h1012, 1'b1, 4'b0000, 1'b1});
      end
      step(1, 0, 1, NOP, '0, 0, 4'd0, '0);
      step(0, 1, 1, JE, 32'h0, 0, 4'd2, 32'h10);
      total++;
      if (obs[0] !== {32'h1002, 1'b1, 4'b0000, 1'b1}) begin
         bad++; $display("FAIL je_not_taken: got %h want %h", obs[0], {32'h1002, 1'b1, 4'b0000, 1'b1});
      end
   endtask

   task automatic test_back_to_back();
      step(1, 0, 1, NOP, '0, 0, 4'd0, '0);
      for (int i = 1; i <= 3; i++) begin
         step(0, 1, 1, NOP, '0, 0, 4'd3, 32'hdead);
         total++;
         if (obs[0] !== {RST_IP + 32'(3 * i), 1'b1, 4'b0000, 1'b1}) begin
            bad++;
            $display("FAIL back_to_back[%0d]: got %h want %h", i, obs[0], {RST_IP + 32'(3 * i), 1'b1, 4'b0000, 1'b1});
         end
      end
   endtask

   task automatic test_call_ret();
      step(1, 0, 1, NOP, '0, 0, 4'd0, '0);
      step(0, 1, 1, JMPI, '0, 0, 4'd2, 32'h100);
      step(0, 1, 1, CALLI, '0, 0, 4'd5, 32'h400);
      total++;
      if (obs[0] !== {32'h400, 1'b1, 4'b0000, 1'b1}) begin
         bad++; $display("FAIL call: got %h want %h", obs[0], {32'h400, 1'b1, 4'b0000, 1'b1});
      end
      step(0, 1, 1, RET, '0, 0, 4'd1, 32'h105);
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs[k] !== {32'h105, 1'b1, 4'b0000, 1'b1}) begin
            bad++; $display("FAIL ret_match dut%0d: got %h want %h", k, obs[k], {32'h105, 1'b1, 4'b0000, 1'b1});
         end
      end
   endtask

   task automatic test_mismatch();
      step(1, 0, 1, NOP, '0, 0, 4'd0, '0);
      step(0, 1, 1, JMPI, '0, 0, 4'd2, 32'h100);
      step(0, 1, 1, CALLI, '0, 0, 4'd5, 32'h400);
      step(0, 1, 1, RET, '0, 0, 4'd1, 32'h999);
      total++;
      if (obs[0] !== {32'h999, 1'b1, 4'b1001, 1'b0}) begin
         bad++; $display("FAIL mismatch_halt: got %h want %h", obs[0], {32'h999, 1'b1, 4'b1001, 1'b0});
      end
      total++;
      if (obs[1] !== {32'h999, 1'b1, 4'b1000, 1'b1}) begin
         bad++; $display("FAIL mismatch_flag: got %h want %h", obs[1], {32'h999, 1'b1, 4'b1000, 1'b1});
      end
      step(0, 1, 1, JMPI, '0, 0, 4'd1, 32'h777);
      total++;
      if (obs[0] !== {32'h999, 1'b0, 4'b1001, 1'b0}) begin
         bad++; $display("FAIL fault_stall: got %h want %h", obs[0], {32'h999, 1'b0, 4'b1001, 1'b0});
      end
      total++;
      if (obs[1] !== {32'h777, 1'b1, 4'b1000, 1'b1}) begin
         bad++; $display("FAIL noflt_run: got %h want %h", obs[1], {32'h777, 1'b1, 4'b1000, 1'b1});
      end
      step(1, 1, 1, JMPI, '0, 0, 4'd1, 32'h777);
      total++;
      if (obs[0] !== {RST_IP, 1'b0, 4'b0000, 1'b1}) begin
         bad++; $display("FAIL fault_reset: got %h want %h", obs[0], {RST_IP, 1'b0, 4'b0000, 1'b1});
      end
   endtask

   task automatic test_overflow();
      logic [31:0] tgt;
      step(1, 0, 1, NOP, '0, 0, 4'd0, '0);
      for (int i = 0; i < 5; i++) step(0, 1, 1, CALLI, '0, 0, 4'd1, 32'h2000 + 32'(i * 16));
      total++;
      if (obs[0] !== {32'h2040, 1'b1, 4'b0010, 1'b1}) begin
         bad++; $display("FAIL overflow: got %h want %h", obs[0], {32'h2040, 1'b1, 4'b0010, 1'b1});
      end
      for (int j = 0; j < 4; j++) begin
         tgt = 32'h2031 - 32'(j * 16);
         step(0, 1, 1, RET, '0, 0, 4'd1, tgt);
         total++;
         if (obs[0] !== {tgt, 1'b1, 4'b0010, 1'b1}) begin
            bad++; $display("FAIL ret_after_ovf[%0d]: got %h want %h", j, obs[0], {tgt, 1'b1, 4'b0010, 1'b1});
         end
      end
      step(0, 1, 1, RET, '0, 0, 4'd1, 32'h1001);
      total++;
      if (obs[0] !== {32'h1001, 1'b1, 4'b0111, 1'b0}) begin
         bad++; $display("FAIL underflow_halt: got %h want %h", obs[0], {32'h1001, 1'b1, 4'b0111, 1'b0});
      end
      total++;
      if (obs[1] !== {32'h1001, 1'b1, 4'b0110, 1'b1}) begin
         bad++; $display("FAIL underflow_flag: got %h want %h", obs[1], {32'h1001, 1'b1, 4'b0110, 1'b1});
      end
   endtask

   task automatic test_wrap();
      step(1, 0, 1, NOP, '0, 0, 4'd0, '0);
      step(0, 1, 1, JMPI, '0, 0, 4'd1, 32'hFFFF_FFFE);
      step(0, 1, 1, NOP, '0, 0, 4'd4, 32'h1234);
      total++;
      if (obs[0] !== {32'h2, 1'b1, 4'b0000, 1'b1}) begin
         bad++; $display("FAIL seq_wrap: got %h want %h", obs[0], {32'h2, 1'b1, 4'b0000, 1'b1});
      end
      step(0, 1, 1, JMPR, '0, 0, 4'd2, 32'hFFFF_FFF0);
      total++;
      if (obs[0] !== {32'hFFFF_FFF4, 1'b1, 4'b0000, 1'b1}) begin
         bad++; $display("FAIL rel_wrap: got %h want %h", obs[0], {32'hFFFF_FFF4, 1'b1, 4'b0000, 1'b1});
      end
   endtask

   task automatic test_stall_reset();
      step(1, 0, 1, NOP, '0, 0, 4'd0, '0);
      step(0, 1, 0, JMPI, '0, 0, 4'd1, 32'h500);
      total++;
      if (obs[0] !== {32'h500, 1'b1, 4'b0000, 1'b0}) begin
         bad++; $display("FAIL stall_accept: got %h want %h", obs[0], {32'h500, 1'b1, 4'b0000, 1'b0});
      end
      step(0, 1, 0, JMPI, '0, 0, 4'd1, 32'h600);
      step(0, 1, 0, JMPI, '0, 0, 4'd1, 32'h600);
      total++;
      if (obs[0] !== {32'h500, 1'b1, 4'b0000, 1'b0}) begin
         bad++; $display("FAIL stall_hold: got %h want %h", obs[0], {32'h500, 1'b1, 4'b0000, 1'b0});
      end
      step(1, 1, 0, JMPI, '0, 0, 4'd1, 32'h600);
      total++;
      if (obs[0] !== {RST_IP, 1'b0, 4'b0000, 1'b1}) begin
         bad++; $display("FAIL stall_reset: got %h want %h", obs[0], {RST_IP, 1'b0, 4'b0000, 1'b1});
      end
   endtask

   task automatic test_random();
      logic [37:0] exp_v;
      logic [31:0] a;
      logic [6:0]  o;
      int          fault_age = 0;
      bit          r;
      step(1, 0, 1, NOP, '0, 0, 4'd0, '0);
      for (int n = 0; n < 3000; n++) begin
         o = OPC_TAB[$urandom_range(27)];
         a = $urandom;
         if (o == RET && m_cnt[0] > 0 && $urandom_range(7) != 0) a = m_ras[0][m_cnt[0] - 1];
         fault_age = m_fault[0] ? fault_age + 1 : 0;
         r = ($urandom_range(99) == 0) || (fault_age > 6);
         step(r, $urandom_range(3) != 0, $urandom_range(3) != 0, o, $urandom,
              $urandom_range(1) == 1, 4'($urandom_range(15)), a);
         for (int k = 0; k < 2; k++) begin
            exp_v = {m_eip[k], m_ov[k], m_mis[k], m_und[k], m_ovf[k], m_fault[k],
                     !m_fault[k] && (!m_ov[k] || out_ready)};
            total++;
            if (obs[k] !== exp_v) begin
               bad++;
               $display("FAIL random[%0d] dut%0d opc=%h: got %h want %h", n, k, o, obs[k], exp_v);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opc = NOP; eflags = '0;
      ecx_is_zero = 1'b0; instr_len = '0; address = '0;
      test_reset();
      test_jcc();
      test_back_to_back();
      test_call_ret();
      test_mismatch();
      test_overflow();
      test_wrap();
      test_stall_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
